// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Optional hit/mispredict statistics are built when BTP_STATS_EN is defined.
module branch_target_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int INDEX_W = $clog2(ENTRIES),
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              predict_taken,
  output logic [ADDR_W-1:0] predict_target,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_mispredict,
  input  logic              flush,
  output logic [CNT_W-1:0]  stat_lookups,
  output logic [CNT_W-1:0]  stat_mispredicts
);

  localparam int TAG_W = ADDR_W - INDEX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [ADDR_W-1:0]  targets [ENTRIES];
  logic [1:0]         ctrs    [ENTRIES];

  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               hit;
  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;

  assign lk_idx = lookup_pc[INDEX_W-1:0];
  assign lk_tag = lookup_pc[ADDR_W-1:INDEX_W];
  assign hit    = valid[lk_idx] && (tags[lk_idx] == lk_tag);

  assign predict_taken  = hit && ctrs[lk_idx][1];
  assign predict_target = predict_taken ? targets[lk_idx]
                                        : lookup_pc + ADDR_W'(1);

  assign up_idx = update_pc[INDEX_W-1:0];
  assign up_tag = update_pc[ADDR_W-1:INDEX_W];
  assign up_hit = valid[up_idx] && (tags[up_idx] == up_tag);

  // Flush wins over a same-cycle update; the update is simply lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tags[i]    <= '0;
        targets[i] <= '0;
        ctrs[i]    <= 2'd1;
      end
    end else if (flush) begin
      valid <= '0;
    end else if (update_valid) begin
      if (up_hit) begin
        if (update_taken) begin
          targets[up_idx] <= update_target;
          if (ctrs[up_idx] != 2'd3)
            ctrs[up_idx] <= ctrs[up_idx] + 2'd1;
        end else if (ctrs[up_idx] != 2'd0) begin
          ctrs[up_idx] <= ctrs[up_idx] - 2'd1;
        end
      end else if (update_taken) begin
        valid[up_idx]   <= 1'b1;
        tags[up_idx]    <= up_tag;
        targets[up_idx] <= update_target;
        ctrs[up_idx]    <= 2'd2;
      end
    end
  end

`ifdef BTP_STATS_EN
  logic [CNT_W-1:0] lookups_q;
  logic [CNT_W-1:0] mispredicts_q;

  // Mispredicts still count while a flush is in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lookups_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      if (hit && (lookups_q != '1))
        lookups_q <= lookups_q + CNT_W'(1);
      if (update_valid && update_mispredict && (mispredicts_q != '1))
        mispredicts_q <= mispredicts_q + CNT_W'(1);
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_mispredicts = mispredicts_q;
`else
  logic unused_mispredict;
  assign unused_mispredict = update_mispredict;
  assign stat_lookups      = '0;
  assign stat_mispredicts  = '0;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor (CNT_W=2 to reach saturation).
// Statistics expectations follow BTP_STATS_EN.
module tb_branch_target_predictor;

`ifdef BTP_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic        flush;
  logic [1:0]  stat_lookups;
  logic [1:0]  stat_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_target_predictor #(
    .ADDR_W (32),
    .ENTRIES(16),
    .CNT_W  (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .lookup_pc        (lookup_pc),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_target    (update_target),
    .update_mispredict(update_mispredict),
    .flush            (flush),
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic mis);
    update_valid      = 1'b1;
    update_pc         = pc;
    update_taken      = tk;
    update_target     = tgt;
    update_mispredict = mis;
    tick();
    update_valid      = 1'b0;
    update_mispredict = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tgt);
    lookup_pc = pc;
    #1;
    chk({tag, "_tk"}, {31'd0, predict_taken}, {31'd0, tk});
    chk({tag, "_tgt"}, predict_target, tgt);
  endtask

  initial begin
    reset = 1'b1;
    lookup_pc = 32'h20;
    update_valid = 1'b0;
    update_pc = '0;
    update_taken = 1'b0;
    update_target = '0;
    update_mispredict = 1'b0;
    flush = 1'b0;
    #1;
    look("rst", 32'h20, 1'b0, 32'h21);
    chk("rst_slk", {30'd0, stat_lookups}, 32'd0);
    chk("rst_smp", {30'd0, stat_mispredicts}, 32'd0);
    tick();
    tick();
    reset = 1'b0;

    upd(32'h23, 1'b1, 32'h40, 1'b0);
    look("alloc", 32'h23, 1'b1, 32'h40);
    look("alias", 32'h33, 1'b0, 32'h34);
    look("wrap", 32'hFFFF_FFFF, 1'b0, 32'h0);

    // same-cycle lookup sees the pre-update counter (2)
    lookup_pc = 32'h23;
    update_valid = 1'b1;
    update_pc = 32'h23;
    update_taken = 1'b0;
    #1;
    chk("same_cyc", {31'd0, predict_taken}, 32'd1);
    tick();
    update_valid = 1'b0;
    upd(32'h23, 1'b0, 32'h0, 1'b0);
    look("ctr0", 32'h23, 1'b0, 32'h24);
    upd(32'h23, 1'b1, 32'h40, 1'b0);
    look("ctr1", 32'h23, 1'b0, 32'h24);
    upd(32'h23, 1'b1, 32'h40, 1'b0);
    look("ctr2", 32'h23, 1'b1, 32'h40);

    for (int i = 0; i < 5; i++) upd(32'h23, 1'b1, 32'h40, 1'b0);
    upd(32'h23, 1'b0, 32'h0, 1'b0);
    look("sat3", 32'h23, 1'b1, 32'h40);
    upd(32'h33, 1'b1, 32'h50, 1'b0);
    look("evict_old", 32'h23, 1'b0, 32'h24);
    look("evict_new", 32'h33, 1'b1, 32'h50);

    flush = 1'b1;
    upd(32'h05, 1'b1, 32'h60, 1'b0);
    flush = 1'b0;
    look("fl_05", 32'h05, 1'b0, 32'h06);
    look("fl_33", 32'h33, 1'b0, 32'h34);

    upd(32'h23, 1'b1, 32'h40, 1'b0);
    look("realloc", 32'h23, 1'b1, 32'h40);
    reset = 1'b1;
    #1;
    look("async_rst", 32'h23, 1'b0, 32'h24);
    reset = 1'b0;
    tick();
    lookup_pc = 32'h20;

    // statistics: four mispredicts on a non-allocating update
    for (int i = 0; i < 4; i++) upd(32'h10, 1'b0, 32'h0, 1'b1);
    chk("st_mis", {30'd0, stat_mispredicts}, STATS * 3);
    chk("st_lk0", {30'd0, stat_lookups}, 32'd0);
    upd(32'h23, 1'b1, 32'h40, 1'b0);
    lookup_pc = 32'h23;
    tick();
    tick();
    tick();
    lookup_pc = 32'h20;
    #1;
    chk("st_lk3", {30'd0, stat_lookups}, STATS * 3);
    look("post_rst", 32'h23, 1'b1, 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch target buffer with 2-bit saturating direction counters, sitting beside the fetch-stage PC register of the 5-stage pipeline. Fetch presents the current PC each cycle and receives a combinational taken/target prediction for next-PC selection. Execute reports resolved control-flow outcomes, which train the table on the following clock edge. This replaces decode-stage fast branching as the primary redirect source; decode/execute redirect remains the correction path.

## Interface
- ADDR_W, 32, PC width. PCs are word addresses; sequential next PC is pc+1.
- ENTRIES, 16, table depth. Must be a power of 2, at least 2.
- INDEX_W, $clog2(ENTRIES), index width. Derived; do not override.
- CNT_W, 16, width of each statistics counter.

Ports:
- clock  in  1  master clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- lookup_pc  in  ADDR_W  current fetch PC.
- predict_taken  out  1  predicted redirect for lookup_pc (combinational).
- predict_target  out  ADDR_W  predicted next PC (combinational).
- update_valid  in  1  resolved control-flow instruction present this cycle.
- update_pc  in  ADDR_W  PC of the resolved instruction.
- update_taken  in  1  actual outcome.
- update_target  in  ADDR_W  actual target when taken.
- update_mispredict  in  1  execute detected a wrong fetch-stage prediction.
- flush  in  1  synchronous invalidate of every entry.
- stat_lookups  out  CNT_W  count of lookups that hit.
- stat_mispredicts  out  CNT_W  count of update_valid & update_mispredict.

## Operation
- Entry fields: valid, tag = pc[ADDR_W-1:INDEX_W], target (ADDR_W bits), 2-bit counter ctr. Index = pc[INDEX_W-1:0].
- Lookup: hit = valid[idx] & (tag[idx] == lookup_pc tag). predict_taken = hit & ctr[idx][1]. predict_target = predict_taken ? target[idx] : lookup_pc+1, with wrap modulo 2^ADDR_W.
- Update when update_valid:
  - Hit with update_taken: ctr saturating increment, max 3; target <= update_target.
  - Hit with not taken: ctr saturating decrement, min 0; target unchanged.
  - Miss with taken: allocate or overwrite the indexed entry. valid=1, tag and target written, ctr=2 (weakly taken).
  - Miss with not taken: no change.
- Flush clears all valid bits; ctr and target are don't-care. Flush has priority over a same-cycle update; the update is dropped.
- Aliasing: direct-mapped. A taken miss evicts the current occupant.

## Timing
- Lookup is purely combinational from lookup_pc to the predict outputs, with zero latency.
- Updates become visible to lookup one cycle after the update edge. A same-cycle lookup of the index being updated sees the pre-update contents.
- Reset values: all valid=0, all ctr=1, all targets 0. stat_lookups=0 and stat_mispredicts=0. Hence predict_taken=0 and predict_target=lookup_pc+1.
- Reset asserted mid-operation clears the table immediately, regardless of clock. The first update after deassertion is accepted on the next rising edge.
- Statistics counters saturate at 2^CNT_W-1 and do not wrap. They are not cleared by flush.

## Configuration
- BTP_STATS_EN:
  - Defined: stat_lookups increments on every rising edge where hit=1. stat_mispredicts increments on every edge where update_valid & update_mispredict, including cycles where flush is also asserted.
  - Undefined: no counter registers are built, and both stat outputs are constant 0.
  - Prediction behaviour is identical with and without the macro.

## Test plan
- Reset with lookup_pc=0x20 -> predict_taken=0, predict_target=0x21. Both stats read 0.
- Update pc=0x23, taken, target=0x40. Next cycle lookup 0x23 -> taken=1, target=0x40. Lookup 0x33 (same index, other tag) -> taken=0, target=0x34.
- Starting from ctr=2, apply two not-taken updates of 0x23 -> predict_taken=0, predict_target=0x24. One taken update -> ctr=1, still not taken. A second taken update -> ctr=2, taken, target=0x40.
- Five taken updates of 0x23 (saturate at 3), then one not-taken -> predict_taken stays 1. Taken miss on 0x33 with target 0x50 -> lookup 0x23 now misses, lookup 0x33 -> 0x50.
- Flush together with a taken update of 0x05 -> all lookups miss next cycle, including 0x05. Reset pulsed mid-sequence, between clock edges -> outputs return to reset values immediately.
- BTP_STATS_EN defined, CNT_W=2:
  - Four update_mispredict pulses -> stat_mispredicts=3 (saturated).
  - Three cycles with a hit -> stat_lookups=3.
  - Without the macro both outputs stay 0.
